// File: rtl/pll_lock_reset_seq.sv
// Lock-to-reset sequencer: synchronizes PLL lock, holds the downstream reset until lock
// has been stable, and pulses the PLL reset whenever lock does not arrive in time.
module pll_lock_reset_seq #(
  parameter int STABLE_CYCLES  = 1024,
  parameter int TIMEOUT_CYCLES = 2500000,
  parameter int PLLRST_CYCLES  = 16,
  parameter int CNT_W          = 8
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             locked,
  output logic             pll_rst,
  output logic             rst_out_n,
  output logic             ready,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] loss_cnt,
  output logic [CNT_W-1:0] retry_cnt
);

  localparam int MAX_A   = (STABLE_CYCLES > TIMEOUT_CYCLES) ? STABLE_CYCLES : TIMEOUT_CYCLES;
  localparam int MAX_CYC = (MAX_A > PLLRST_CYCLES) ? MAX_A : PLLRST_CYCLES;
  localparam int TMR_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [TMR_W-1:0] STABLE_LAST  = TMR_W'(STABLE_CYCLES - 1);
  localparam logic [TMR_W-1:0] TIMEOUT_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TMR_W-1:0] PLLRST_LAST  = TMR_W'(PLLRST_CYCLES - 1);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABLE    = 2'd1,
    RUN       = 2'd2,
    PLL_RESET = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic             locked_p0, locked_s;
  logic             loss_inc, retry_inc;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Two-flop synchronizer for the asynchronous lock input
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      locked_p0 <= 1'b0;
      locked_s  <= 1'b0;
    end else begin
      locked_p0 <= locked;
      locked_s  <= locked_p0;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= WAIT_LOCK;
      timer_q   <= '0;
      loss_cnt  <= '0;
      retry_cnt <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      if (loss_inc)  loss_cnt  <= sat_inc(loss_cnt);
      if (retry_inc) retry_cnt <= sat_inc(retry_cnt);
    end
  end

  // Next-state logic; the timer clears on every state change
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q + TMR_W'(1);
    loss_inc  = 1'b0;
    retry_inc = 1'b0;
    case (state_q)
      WAIT_LOCK: begin
        if (locked_s) begin
          state_d = STABLE;
          timer_d = '0;
        end else if (timer_q == TIMEOUT_LAST) begin
          state_d   = PLL_RESET;
          timer_d   = '0;
          retry_inc = 1'b1;
        end
      end
      STABLE: begin
        if (!locked_s) begin
          state_d = WAIT_LOCK;
          timer_d = '0;
        end else if (timer_q == STABLE_LAST) begin
          state_d = RUN;
          timer_d = '0;
        end
      end
      RUN: begin
        timer_d = '0;
        if (!locked_s) begin
          state_d  = WAIT_LOCK;
          loss_inc = 1'b1;
        end
      end
      PLL_RESET: begin
        if (timer_q == PLLRST_LAST) begin
          state_d = WAIT_LOCK;
          timer_d = '0;
        end
      end
    endcase
  end

  // Moore decode of the registered state only, so reset drops pll_rst asynchronously
  assign state     = state_q;
  assign ready     = (state_q == RUN);
  assign rst_out_n = (state_q == RUN);
  assign pll_rst   = (state_q == PLL_RESET);

endmodule

// File: tb/tb_pll_lock_reset_seq.sv
// Scenario bench for pll_lock_reset_seq with short timing parameters; expected event
// edges are queued when stimulus is driven and checked when the DUT produces them.
module tb_pll_lock_reset_seq;

  localparam int CNT_W = 4;

  logic             CLK = 1'b0;
  logic             RST_N = 1'b0;
  logic             locked = 1'b0;
  logic             pll_rst, rst_out_n, ready;
  logic [1:0]       state;
  logic [CNT_W-1:0] loss_cnt, retry_cnt;

  int tests = 0;
  int fails = 0;
  int edge_no = 0;
  int exp_q[$];

  pll_lock_reset_seq #(
    .STABLE_CYCLES(8), .TIMEOUT_CYCLES(32), .PLLRST_CYCLES(4), .CNT_W(CNT_W)
  ) dut (
    .CLK(CLK), .RST_N(RST_N), .locked(locked), .pll_rst(pll_rst),
    .rst_out_n(rst_out_n), .ready(ready), .state(state),
    .loss_cnt(loss_cnt), .retry_cnt(retry_cnt)
  );

  always #5 CLK = ~CLK;

  // Edge 1 is the first rising edge after RST_N releases
  always @(posedge CLK) begin
    if (!RST_N) edge_no <= 0;
    else        edge_no <= edge_no + 1;
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic run_to(input int e);
    while (edge_no < e) step();
  endtask

  task automatic chk(input string name, input int got, input int exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic test_reset();
    locked = 1'b0;
    RST_N  = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    tests++; if (state !== 2'd0)     begin fails++; $display("FAIL reset_state: got %0d expected 0", state); end
    tests++; if (pll_rst !== 1'b0)   begin fails++; $display("FAIL reset_pll_rst: got %b expected 0", pll_rst); end
    tests++; if (rst_out_n !== 1'b0) begin fails++; $display("FAIL reset_rst_out_n: got %b expected 0", rst_out_n); end
    tests++; if (ready !== 1'b0)     begin fails++; $display("FAIL reset_ready: got %b expected 0", ready); end
    tests++; if (loss_cnt !== '0 || retry_cnt !== '0)
      begin fails++; $display("FAIL reset_counters: got loss=%0d retry=%0d expected 0/0", loss_cnt, retry_cnt); end
    @(negedge CLK);
    RST_N = 1'b1;
  endtask

  task automatic wait_ready(input int budget, output int rise_edge);
    rise_edge = -1;
    for (int i = 0; i < budget; i++) begin
      step();
      if (rst_out_n === 1'b1) begin
        rise_edge = edge_no;
        break;
      end
    end
  endtask

  task automatic pop_check(input string name, input int got);
    int exp;
    tests++;
    if (exp_q.size() == 0) begin
      fails++;
      $display("FAIL %s: got event at %0d expected none", name, got);
    end else begin
      exp = exp_q.pop_front();
      if (got !== exp) begin
        fails++;
        $display("FAIL %s: got edge %0d expected edge %0d", name, got, exp);
      end
    end
  endtask

  task automatic test_clean_lock();
    int rise;
    test_reset();
    run_to(4);
    locked = 1'b1;
    exp_q.push_back(15);
    wait_ready(40, rise);
    pop_check("clean_rise_edge", rise);
    chk("clean_ready", int'(ready), 1);
    chk("clean_state", int'(state), 2);
    chk("clean_pll_rst", int'(pll_rst), 0);
    chk("clean_counters", int'(loss_cnt) + int'(retry_cnt), 0);
  endtask

  task automatic test_glitch();
    int rise;
    test_reset();
    run_to(4);
    locked = 1'b1;
    run_to(9);
    locked = 1'b0;
    run_to(10);
    locked = 1'b1;
    run_to(11);
    chk("glitch_state_stable", int'(state), 1);
    run_to(12);
    chk("glitch_state_wait", int'(state), 0);
    run_to(13);
    chk("glitch_state_restable", int'(state), 1);
    exp_q.push_back(21);
    wait_ready(30, rise);
    pop_check("glitch_rise_edge", rise);
    chk("glitch_loss_cnt", int'(loss_cnt), 0);
  endtask

  task automatic test_timeout();
    logic prev = 1'b0;
    int hi = 0;
    int pulses = 0;
    test_reset();
    for (int i = 0; i < 16; i++) exp_q.push_back(32 + 36 * i);
    while (edge_no < 32 + 36 * 15 + 8) begin
      step();
      if (pll_rst && !prev) begin
        pulses++;
        pop_check("timeout_pulse_edge", edge_no);
        chk("timeout_retry_cnt", int'(retry_cnt), (pulses > 15) ? 15 : pulses);
      end
      if (pll_rst) hi++;
      else if (prev) begin
        chk("timeout_pulse_width", hi, 4);
        hi = 0;
      end
      prev = pll_rst;
    end
    chk("timeout_pulse_count", pulses, 16);
    chk("timeout_queue_drained", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic test_lock_loss();
    int rise;
    test_reset();
    run_to(4);
    locked = 1'b1;
    run_to(20);
    chk("loss_in_run", int'(state), 2);
    locked = 1'b0;
    run_to(21);
    locked = 1'b1;
    run_to(22);
    chk("loss_rst_still_high", int'(rst_out_n), 1);
    chk("loss_cnt_before", int'(loss_cnt), 0);
    run_to(23);
    chk("loss_rst_low", int'(rst_out_n), 0);
    chk("loss_ready_low", int'(ready), 0);
    chk("loss_cnt_after", int'(loss_cnt), 1);
    exp_q.push_back(32);
    wait_ready(30, rise);
    pop_check("loss_rerun_edge", rise);
  endtask

  task automatic test_lock_vs_timeout();
    test_reset();
    run_to(29);
    locked = 1'b1;
    run_to(31);
    chk("simul_state_wait", int'(state), 0);
    run_to(32);
    chk("simul_state_stable", int'(state), 1);
    chk("simul_pll_rst", int'(pll_rst), 0);
    chk("simul_retry_cnt", int'(retry_cnt), 0);
  endtask

  task automatic test_reset_mid_pulse();
    logic prev = 1'b0;
    int rise = -1;
    test_reset();
    run_to(33);
    chk("midrst_pll_rst_before", int'(pll_rst), 1);
    chk("midrst_retry_before", int'(retry_cnt), 1);
    RST_N = 1'b0;
    #1;
    chk("midrst_pll_rst_async", int'(pll_rst), 0);
    chk("midrst_state", int'(state), 0);
    chk("midrst_counters", int'(retry_cnt) + int'(loss_cnt), 0);
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;
    exp_q.push_back(32);
    for (int i = 0; i < 40; i++) begin
      step();
      if (pll_rst && !prev) begin
        rise = edge_no;
        break;
      end
      prev = pll_rst;
    end
    pop_check("midrst_next_pulse_edge", rise);
  endtask

  initial begin
    test_reset();
    test_clean_lock();
    test_glitch();
    test_timeout();
    test_lock_loss();
    test_lock_vs_timeout();
    test_reset_mid_pulse();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pll_lock_reset_seq.md
# pll_lock_reset_seq

Lock-to-reset sequencer on the consuming side of the ECP5 PLL `locked` output. It synchronizes `locked`, requires a stable lock before releasing the downstream active-low reset, and reasserts that reset immediately on loss of lock. If the PLL never locks, it pulses the PLL reset input and retries. It runs on the 25 MHz PLL reference clock and feeds the reset inputs of the fast-clock domains and BSV top-level `RST_N`.

## Interface
- `STABLE_CYCLES`, 1024: consecutive synchronized-locked cycles required before release; must be ≥1.
- `TIMEOUT_CYCLES`, 2500000: cycles in WAIT_LOCK before a PLL reset (100 ms at 25 MHz); must be ≥1.
- `PLLRST_CYCLES`, 16: width of the `pll_rst` pulse in cycles; must be ≥1.
- `CNT_W`, 8: width of the event counters.
- `CLK` input 1: 25 MHz reference clock, the only clock.
- `RST_N` input 1: asynchronous, active-low reset.
- `locked` input 1: PLL lock, asynchronous to `CLK`.
- `pll_rst` output 1: drives the PLL `RST` input; active-high.
- `rst_out_n` output 1: downstream reset; active-low.
- `ready` output 1: high when the clocks are usable.
- `state` output 2: current FSM state encoding.
- `loss_cnt` output CNT_W: lock losses seen in RUN; saturating.
- `retry_cnt` output CNT_W: timeouts that issued a PLL reset; saturating.

## Operation
- Synchronizer: `locked` passes through two flops to produce `locked_s`. Both flops reset to 0.
- State encodings: WAIT_LOCK=0, STABLE=1, RUN=2, PLL_RESET=3.
- Single timer, width clog2 of the maximum of the three cycle parameters. It is cleared on every state change.
- WAIT_LOCK:
  - If `locked_s`=1, go to STABLE.
  - Otherwise, when timer == TIMEOUT_CYCLES-1, go to PLL_RESET and increment `retry_cnt`.
  - Otherwise the timer increments.
  - Lock wins over timeout when both occur in the same cycle.
- STABLE:
  - If `locked_s`=0, go to WAIT_LOCK. This is a glitch; the timer restarts at 0 and no counter increments.
  - Otherwise, when timer == STABLE_CYCLES-1, go to RUN.
  - Otherwise the timer increments.
- RUN:
  - If `locked_s`=0, go to WAIT_LOCK and increment `loss_cnt`.
  - Otherwise stay; the timer is held at 0.
- PLL_RESET:
  - When timer == PLLRST_CYCLES-1, go to WAIT_LOCK.
  - Otherwise the timer increments. `locked_s` is ignored.
- Outputs are Moore outputs, decoded from the registered state with no combinational path from `locked`:
  - `rst_out_n` = `ready` = (state==RUN).
  - `pll_rst` = (state==PLL_RESET).
- Counters saturate at 2^CNT_W-1 with no wrap. They are cleared only by `RST_N`.
- Reset values, asynchronous on `RST_N`=0:
  - state=WAIT_LOCK, timer=0.
  - `pll_rst`=0, `rst_out_n`=0, `ready`=0.
  - `loss_cnt`=0, `retry_cnt`=0.
  - Synchronizer flops = 0.
- Reset mid-operation, including during PLL_RESET, forces the reset values immediately. `pll_rst` drops asynchronously. After `RST_N` releases, operation restarts in WAIT_LOCK with timer 0.

## Timing
- Edge numbering: edge k is the first rising edge at which `locked`=1 is sampled.
  - `locked_s`=1 after edge k+1.
  - state=STABLE after edge k+2.
  - state=RUN after edge k+2+STABLE_CYCLES, so `rst_out_n` rises at edge k+2+STABLE_CYCLES.
- Lock loss: edge j is the first edge sampling `locked`=0 while in RUN.
  - `rst_out_n`=0 and `ready`=0 after edge j+2.
  - `loss_cnt` updates at the same edge.
- Timeout: WAIT_LOCK lasts exactly TIMEOUT_CYCLES cycles when `locked_s` stays 0.
  - `pll_rst` is then high for exactly PLLRST_CYCLES cycles.
  - WAIT_LOCK restarts with a full timeout window.
  - The retry period is TIMEOUT_CYCLES+PLLRST_CYCLES cycles.
- STABLE lasts exactly STABLE_CYCLES cycles when there is no glitch.
- Counter increments are visible on the same edge as the state change that causes them.

## Test plan
All scenarios use STABLE_CYCLES=8, TIMEOUT_CYCLES=32, PLLRST_CYCLES=4, CNT_W=4.
- Clean lock: release `RST_N`, then drive `locked`=1 first sampled at edge 5 → `rst_out_n`/`ready` rise at edge 15. `pll_rst` stays 0; both counters stay 0.
- Glitch in STABLE: `locked` high for 5 cycles, low for 1, then high → state returns to 0 and STABLE restarts. `rst_out_n` rises 8 cycles after the second STABLE entry; `loss_cnt`=0.
- Timeout/retry: hold `locked`=0 → `pll_rst` high for cycles 32–35 after reset, then again every 36 cycles. `retry_cnt` increments per pulse and saturates at 15 after 15 or more pulses.
- Lock loss in RUN: from RUN, drop `locked` for 1 cycle → `rst_out_n` low 2 edges later and `loss_cnt`=1. RUN is re-entered 8 cycles after re-entering STABLE.
- Simultaneous lock and timeout: `locked_s` first high in the cycle where timer=31 → next state is STABLE, not PLL_RESET; `retry_cnt` unchanged.
- Reset mid-pulse: assert `RST_N`=0 during the 2nd PLL_RESET cycle → `pll_rst`=0 immediately, counters 0, state 0. After release, the next `pll_rst` occurs 32 cycles later.
